// File: rtl/push_conditioner.sv
// push_conditioner
//   Synchronises and debounces the board push buttons, then produces clean
//   single-cycle press / release / auto-repeat strobes and a long-press level.
//   Each button is an independent lane; lanes share no state.
//
// Ports
//   clk_osc      in   board oscillator, all state on rising edge
//   resetn       in   asynchronous, active-low reset
//   btn_raw      in   [N_BTN] raw pad levels, active-high, asynchronous
//   btn_level    out  [N_BTN] debounced level
//   btn_press    out  [N_BTN] one-cycle strobe on debounced rising edge
//   btn_release  out  [N_BTN] one-cycle strobe on debounced falling edge
//   btn_step     out  [N_BTN] press strobe plus auto-repeat (REPEAT_MASK lanes)
//   btn_long     out  [N_BTN] high while held for at least LONG_CYCLES
module push_conditioner #(
    parameter int unsigned             N_BTN           = 5,
    parameter int unsigned             DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned             REPEAT_DELAY    = 50_000_000,
    parameter int unsigned             REPEAT_PERIOD   = 10_000_000,
    parameter logic [N_BTN-1:0]        REPEAT_MASK     = 5'b00011,
    parameter int unsigned             LONG_CYCLES     = 200_000_000
) (
    input  logic             clk_osc,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step,
    output logic [N_BTN-1:0] btn_long
);

    localparam int unsigned HC_MAX = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
    localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DCW    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HCW    = $clog2(HC_MAX + 1);
    localparam int unsigned RCW    = $clog2(RC_MAX + 1);

    localparam logic [DCW-1:0] DC_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HC_SAT    = HCW'(HC_MAX);
    localparam logic [HCW-1:0] HC_LONG   = HCW'(LONG_CYCLES);
    localparam logic [RCW-1:0] RC_DELAY  = RCW'(REPEAT_DELAY);
    localparam logic [RCW-1:0] RC_PERIOD = RCW'(REPEAT_PERIOD);
    localparam logic [RCW-1:0] RC_ONE    = RCW'(1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } lane_state_t;

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        logic           s1, s2;
        logic [DCW-1:0] dc_q, dc_nx;
        logic [HCW-1:0] hc_q, hc_nx;
        logic [RCW-1:0] rc_q, rc_nx;
        lane_state_t    state_q, state_nx;
        logic           press_q, press_nx;
        logic           release_q, release_nx;
        logic           step_q, step_nx;
        logic           long_q, long_nx;
        logic           level;
        logic           accept;

        assign level  = (state_q == PRESSED);
        // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive
        // edge at which s2 disagrees with the debounced level.
        assign accept = (s2 != level) && (dc_q == DC_LAST);

        always_ff @(posedge clk_osc or negedge resetn) begin
            if (!resetn) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                dc_q      <= '0;
                hc_q      <= '0;
                rc_q      <= '0;
                state_q   <= RELEASED;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                s1        <= btn_raw[g];
                s2        <= s1;
                dc_q      <= dc_nx;
                hc_q      <= hc_nx;
                rc_q      <= rc_nx;
                state_q   <= state_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
                step_q    <= step_nx;
                long_q    <= long_nx;
            end
        end

        always_comb begin
            state_nx   = state_q;
            dc_nx      = dc_q;
            hc_nx      = hc_q;
            rc_nx      = rc_q;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            step_nx    = 1'b0;
            long_nx    = long_q;

            if (s2 == level || accept) begin
                dc_nx = '0;
            end else begin
                dc_nx = dc_q + 1'b1;
            end

            case (state_q)
                RELEASED: begin
                    if (accept) begin
                        state_nx = PRESSED;
                        press_nx = 1'b1;
                        step_nx  = 1'b1;
                        hc_nx    = '0;
                        rc_nx    = REPEAT_MASK[g] ? RC_DELAY : '0;
                        long_nx  = 1'b0;
                    end
                end
                PRESSED: begin
                    if (accept) begin
                        // Release wins over any repeat step due this edge.
                        state_nx   = RELEASED;
                        release_nx = 1'b1;
                        hc_nx      = '0;
                        rc_nx      = '0;
                        long_nx    = 1'b0;
                    end else begin
                        if (hc_q != HC_SAT) begin
                            hc_nx = hc_q + 1'b1;
                        end
                        // rc counts down to the next repeat step so that the
                        // periodic schedule keeps running after hc saturates.
                        if (REPEAT_MASK[g]) begin
                            if (rc_q == RC_ONE) begin
                                step_nx = 1'b1;
                                rc_nx   = RC_PERIOD;
                            end else begin
                                rc_nx = rc_q - 1'b1;
                            end
                        end
                        if (hc_nx >= HC_LONG) begin
                            long_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = RELEASED;
            endcase
        end

        assign btn_level[g]   = level;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_step[g]    = step_q;
        assign btn_long[g]    = long_q;
    end

endmodule

// File: doc/push_conditioner.md
# push_conditioner

Input-side conditioner for the board's five push buttons (u, d, l, r, m). It synchronises the raw pad levels to clk_osc and debounces them. It then emits clean single-cycle press, release and auto-repeat strobes, plus a long-press flag. The service blocks (time set, alarm set, stopwatch, alarm check) consume these strobes instead of the raw `push` pins.

## Interface
- N_BTN, 5, number of buttons; bit order u=0, d=1, l=2, r=3, m=4
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk_osc cycles needed to accept a level change (10 ms at 100 MHz); minimum 2
- REPEAT_DELAY, 50_000_000, hold cycles before the first auto-repeat step; must be at least 1
- REPEAT_PERIOD, 10_000_000, cycles between later auto-repeat steps; must be at least 1
- REPEAT_MASK, 5'b00011, buttons that auto-repeat (u, d by default)
- LONG_CYCLES, 200_000_000, hold cycles before btn_long asserts; must be at least 1
- clk_osc  in  1  board oscillator; all state on its rising edge
- resetn  in  1  asynchronous, active-low reset
- btn_raw  in  N_BTN  raw pad levels, active-high, asynchronous to clk_osc
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  one-cycle strobe on a debounced rising edge
- btn_release  out  N_BTN  one-cycle strobe on a debounced falling edge
- btn_step  out  N_BTN  one-cycle strobe on press, then auto-repeat strobes (masked buttons only)
- btn_long  out  N_BTN  level, high while held for at least LONG_CYCLES

## Operation
- Each button is an independent identical lane; lanes share no state.
- Synchroniser: two flops per lane, s1 then s2, both reset to 0.
- Debounce counter dc, width $clog2(DEBOUNCE_CYCLES):
  - cleared whenever s2 == btn_level;
  - otherwise incremented each cycle.
- When s2 != btn_level and dc == DEBOUNCE_CYCLES-1 on the same edge:
  - btn_level toggles;
  - dc clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles (measured at s2) leaves btn_level unchanged.
- Lane FSM states:
  - RELEASED: btn_level=0; goes to PRESSED on an accepted rise.
  - PRESSED: goes to RELEASED on an accepted fall.
- btn_press is high exactly in the first cycle that btn_level=1.
- btn_release is high exactly in the first cycle that btn_level=0 after PRESSED.
- Hold counter hc:
  - set to 0 in the press cycle;
  - increments each PRESSED cycle;
  - saturates at max(LONG_CYCLES, REPEAT_DELAY); never wraps.
- Repeat countdown rc is used for periodic steps; no modulo arithmetic.
- btn_step is high in the press cycle for every button.
- For REPEAT_MASK lanes, btn_step is also high in each cycle where hc == REPEAT_DELAY + n*REPEAT_PERIOD (n ≥ 0), for as long as the button is held.
- For unmasked lanes, btn_step == btn_press.
- btn_long:
  - rises in the cycle where hc == LONG_CYCLES;
  - stays high through PRESSED;
  - falls in the same cycle btn_level falls.
- Simultaneous buttons: lanes evolve independently; multiple strobe bits may be high in the same cycle.
- Released and pressed transitions are strictly alternating per lane; no two press strobes occur without a release between them.

## Timing
- Reset values: every output is 0; s1, s2, dc, hc and rc are 0; all lanes are in RELEASED.
- Reset assertion clears all state immediately (asynchronous).
- No release strobe is generated for a button that was held when reset asserted.
- If a button is still held after reset deasserts, it is treated as a fresh press: press and step strobes follow after the normal latency.
- Press latency: raw stable high from sampling edge E0 gives btn_level=1 and btn_press=1 at edge E0+DEBOUNCE_CYCLES+1.
- Release latency is the same.
- Every strobe is exactly one clk_osc cycle wide.
- All outputs are registered; there is no combinational path from btn_raw.
- A press held shorter than LONG_CYCLES never asserts btn_long.
- A release in the same cycle a repeat step would fire suppresses that step (btn_step=0).

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, LONG_CYCLES=30, REPEAT_MASK=5'b00011.

1. Clean press of u: raw[0] rises before edge E0 and is held → btn_level[0] and btn_press[0] rise at edge E0+5. btn_press[0] is high for 1 cycle; btn_step[0] is high in the same cycle.
2. Bounce on m: raw[4] toggles high 3 cycles, low 2, high 3, low → btn_level, btn_press and btn_step all stay 0 throughout.
3. Auto-repeat on d, held 50 cycles after acceptance:
   - btn_step[1] pulses at hc = 0, 20, 28, 36, 44;
   - btn_long[1] rises at hc=30;
   - release: btn_release[1] pulses 5 edges after raw falls, and btn_long[1] drops in that cycle.
4. Unmasked l held 50 cycles → btn_step[2] pulses once (hc=0) only; btn_long[2] rises at hc=30.
5. u and r pressed on the same edge → btn_press[0] and btn_press[3] are high in the same cycle; releasing r leaves btn_level[0]=1 with no strobe on lane 0.
6. resetn pulsed low while u is held at hc=25:
   - during reset all outputs are 0 immediately, with no release strobe;
   - after deassert with u still held, btn_press[0] fires at deassert edge + DEBOUNCE_CYCLES + 2 (one extra edge for s1 to capture);
   - hc restarts from 0.
